eth_tx_sched: RTL and testbench

//  Schedules the single Ethernet transmitter between NREQ frame sources. Round-robin grants one

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_tx_sched_if.sv | 32 +++
 rtl/eth_rr_arb.sv | 31 +++
 rtl/eth_tx_sched.sv | 140 ++++++++++++++
 tb/tb_eth_tx_sched.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX scheduler.
package eth_pkg;

    localparam int ETH_ADDR_W    = 10;
    localparam int ETH_DATA_W    = 8;
    localparam int ETH_FRAME_LEN = 526;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } eth_sched_state_t;

endpackage

// File: rtl/eth_tx_sched_if.sv
// Producer/transmitter side bundle of the TX scheduler; slave is the scheduler view.
interface eth_tx_sched_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic                     clk_en;
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          commit;
    logic [NREQ-1:0]          src_wr_en;
    logic [NREQ*ADDR_W-1:0]   src_wr_addr;
    logic [NREQ*DATA_W-1:0]   src_wr_data;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          done;
    logic                     err;
    logic                     bram_wr_en;
    logic [ADDR_W-1:0]        bram_wr_addr;
    logic [DATA_W-1:0]        bram_wr_data;
    logic                     tx_start;
    logic                     tx_busy;

    modport master (
        output clk_en, req, commit, src_wr_en, src_wr_addr, src_wr_data, tx_busy,
        input  grant, done, err, bram_wr_en, bram_wr_addr, bram_wr_data, tx_start
    );

    modport slave (
        input  clk_en, req, commit, src_wr_en, src_wr_addr, src_wr_data, tx_busy,
        output grant, done, err, bram_wr_en, bram_wr_addr, bram_wr_data, tx_start
    );

endinterface

// File: rtl/eth_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module eth_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin owner of the TX frame BRAM and transmitter: write mux, FSM and optional watchdog.
// Build option: define ETH_TX_SCHED_WDOG_EN to bound the wait for the transmitter.
import eth_pkg::*;

module eth_tx_sched #(
    parameter int NREQ        = 4,
    parameter int ADDR_W      = ETH_ADDR_W,
    parameter int DATA_W      = ETH_DATA_W,
    parameter int WDOG_CYCLES = 2000000
) (
    input logic           clk,
    input logic           rst_n,
    eth_tx_sched_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    eth_sched_state_t state_q;
    logic [NREQ-1:0]  grant_q, done_q;
    logic             tx_start_q;
    logic [IW-1:0]    rr_q, owner_q;

    logic [NREQ-1:0]  arb_gnt_d;
    logic [IW-1:0]    arb_idx_d, rr_d;
    logic             arb_vld_d, own_commit_d, own_req_d;
    logic             wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    eth_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i (bus.req),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt_d),
        .idx_o (arb_idx_d),
        .vld_o (arb_vld_d)
    );

    assign rr_d         = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign own_commit_d = |(bus.commit & grant_q);
    assign own_req_d    = |(bus.req & grant_q);

    // Only the owner reaches the BRAM, and only while it is filling.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (state_q == S_FILL) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q[i]) begin
                    wr_en_d   = bus.src_wr_en[i];
                    wr_addr_d = bus.src_wr_addr[i*ADDR_W +: ADDR_W];
                    wr_data_d = bus.src_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef ETH_TX_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
    logic            err_q;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            rr_q       <= '0;
            owner_q    <= '0;
`ifdef ETH_TX_SCHED_WDOG_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= '0;
`ifdef ETH_TX_SCHED_WDOG_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                // A busy transmitter may be a frame left over from before reset.
                S_IDLE: if (arb_vld_d && !bus.tx_busy) begin
                    grant_q <= arb_gnt_d;
                    owner_q <= arb_idx_d;
                    state_q <= S_FILL;
                end
                S_FILL: begin
                    if (own_commit_d) begin
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
`ifdef ETH_TX_SCHED_WDOG_EN
                        wdog_q     <= '0;
`endif
                    end else if (!own_req_d) begin
                        state_q <= S_RELEASE;
                    end
                end
                S_START: if (bus.tx_busy) begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: if (bus.tx_busy) state_q <= S_WAIT_DONE;
                S_WAIT_DONE: if (!bus.tx_busy) begin
                    done_q  <= grant_q;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    grant_q <= '0;
                    rr_q    <= rr_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef ETH_TX_SCHED_WDOG_EN
            if (state_q == S_START || state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
                if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                    tx_start_q <= 1'b0;
                    done_q     <= grant_q;
                    err_q      <= 1'b1;
                    state_q    <= S_RELEASE;
                end else begin
                    wdog_q <= wdog_q + 1'b1;
                end
            end
`endif
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.bram_wr_en   = wr_en_d;
    assign bus.bram_wr_addr = wr_addr_d;
    assign bus.bram_wr_data = wr_data_d;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed + randomized bench for eth_tx_sched against a round-robin ownership model.
module tb_eth_tx_sched;

    localparam int NREQ = 4, AW = 10, DW = 8, WD = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_tx_sched_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();
    eth_tx_sched #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [1:0] cen_q = 2'd0;
    always @(posedge clk) cen_q <= cen_q + 2'd1;
    assign bus.clk_en = (cen_q == 2'd0);

    int n_chk = 0, n_fail = 0, ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic wait_grant();
        int w = 0;
        while (bus.grant == '0 && w < 20) begin step(); w++; end
    endtask

    task automatic finish_tx(input logic [NREQ-1:0] og, input int own);
        repeat ($urandom_range(0, 4)) begin step(); chk("start_hold", 32'(bus.tx_start), 1); end
        bus.tx_busy = 1'b1;
        step();
        chk("start_drop", 32'(bus.tx_start), 0);
        repeat ($urandom_range(3, 8)) begin step(); chk("done_early", 32'(bus.done), 0); end
        bus.tx_busy = 1'b0;
        step();
        chk("done", 32'(bus.done), 32'(og));
        chk("err_quiet", 32'(bus.err), 0);
        step();
        chk("done_1clk", 32'(bus.done), 0);
        chk("grant_rel", 32'(bus.grant), 0);
        ptr = (own + 1) % NREQ;
    endtask

    // mode: 0 normal, 1 abort in FILL, 2 transmitter never goes busy.
    task automatic frame(input int nwr, input int mode);
        int own;
        logic [NREQ-1:0] og;
        own = pick(bus.req, ptr);
        og  = NREQ'(1) << own;
        wait_grant();
        chk("grant", 32'(bus.grant), 32'(og));
        for (int k = 0; k <= nwr; k++) begin
            bus.src_wr_en   = (k == 0) ? ~og : (NREQ'($urandom) | og);
            bus.src_wr_addr = (NREQ*AW)'({$urandom, $urandom});
            bus.src_wr_data = (NREQ*DW)'($urandom);
            #1;
            chk("wr_en", 32'(bus.bram_wr_en), 32'(bus.src_wr_en[own]));
            if (bus.src_wr_en[own]) begin
                chk("wr_addr", 32'(bus.bram_wr_addr), 32'(bus.src_wr_addr[own*AW +: AW]));
                chk("wr_data", 32'(bus.bram_wr_data), 32'(bus.src_wr_data[own*DW +: DW]));
            end
            step();
        end
        bus.src_wr_en = '0;
        if (mode == 1) begin
            bus.req[own] = 1'b0;
            step();
            chk("abort_start", 32'(bus.tx_start), 0);
            chk("abort_done", 32'(bus.done), 0);
            step();
            chk("abort_grant", 32'(bus.grant), 0);
            chk("abort_done2", 32'(bus.done), 0);
            ptr = (own + 1) % NREQ;
            return;
        end
        bus.commit = ~og;
        step();
        chk("foreign_commit", 32'(bus.tx_start), 0);
        bus.commit = og | NREQ'($urandom);
        if ($urandom_range(0, 1) == 1) bus.req[own] = 1'b0;
        step();
        bus.commit    = '0;
        bus.src_wr_en = '1;
        #1;
        chk("commit_start", 32'(bus.tx_start), 1);
        chk("wr_blocked", 32'(bus.bram_wr_en), 0);
        bus.src_wr_en = '0;
        if (mode == 2) begin
`ifdef ETH_TX_SCHED_WDOG_EN
            for (int n = 2; n <= WD; n++) begin step(); chk("wd_hold", 32'(bus.tx_start), 1); end
            step();
            chk("wd_start", 32'(bus.tx_start), 0);
            chk("wd_done", 32'(bus.done), 32'(og));
            chk("wd_err", 32'(bus.err), 1);
            step();
            chk("wd_done_1clk", 32'(bus.done), 0);
            chk("wd_err_1clk", 32'(bus.err), 0);
            chk("wd_grant", 32'(bus.grant), 0);
            ptr = (own + 1) % NREQ;
            return;
`else
            for (int n = 0; n < 150; n++) begin
                step();
                chk("nowd_start", 32'(bus.tx_start), 1);
                chk("nowd_err", 32'(bus.err), 0);
            end
`endif
        end
        finish_tx(og, own);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int own;
        logic [NREQ-1:0] og;
        bus.req = '0; bus.commit = '0; bus.src_wr_en = '0;
        bus.src_wr_addr = '0; bus.src_wr_data = '0; bus.tx_busy = 1'b0;
        repeat (3) step();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_start", 32'(bus.tx_start), 0);
        chk("rst_wr_en", 32'(bus.bram_wr_en), 0);
        rst_n = 1'b1;
        step();

        bus.req = 4'b0001;
        step();
        chk("grant_latency", 32'(bus.grant), 1);
        frame(526, 0);
        bus.req = '0;
        step();

        repeat (5) begin bus.req = '1; frame(3, 0); end

        bus.req = '1;
        frame(2, 1);
        frame(2, 0);

        repeat (20) begin
            bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        bus.req = 4'b0110;
        step();
        own = pick(bus.req, ptr);
        og  = NREQ'(1) << own;
        wait_grant();
        chk("pre_rst_grant", 32'(bus.grant), 32'(og));
        bus.commit = og;
        step();
        bus.commit  = '0;
        bus.tx_busy = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", 32'(bus.grant), 0);
        chk("midrst_start", 32'(bus.tx_start), 0);
        chk("midrst_done", 32'(bus.done), 0);
        step();
        rst_n = 1'b1;
        ptr = 0;
        repeat (4) begin step(); chk("busy_blocks", 32'(bus.grant), 0); end
        bus.tx_busy = 1'b0;
        step();
        chk("post_rst_grant", 32'(bus.grant), 32'(NREQ'(1) << pick(bus.req, ptr)));
        frame(2, 0);

        bus.req = 4'b1000;
        frame(2, 2);
        bus.req = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
